// File: rtl/fifo_rr_drain_if.sv
// Handshake bundle between fifo_rr_drain and its surroundings.
// Carries the upstream fifo read side (dout/empty/rd_en) and the
// downstream valid/ready output stream (data/src/valid/ready).
// master = the drain block, slave = the fifos plus the dispatch consumer.
interface fifo_rr_drain_if #(
    parameter int DWIDTH    = 16,
    parameter int N_FIFO    = 4,
    parameter int IDX_WIDTH = 2
);
    logic [N_FIFO*DWIDTH-1:0] fifo_dout;
    logic [N_FIFO-1:0]        fifo_empty;
    logic [N_FIFO-1:0]        fifo_rd_en;
    logic [DWIDTH-1:0]        out_data;
    logic [IDX_WIDTH-1:0]     out_src;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  out_ready,
        output fifo_rd_en,
        output out_data,
        output out_src,
        output out_valid
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output out_ready,
        input  fifo_rd_en,
        input  out_data,
        input  out_src,
        input  out_valid
    );
endinterface

// File: rtl/fifo_rr_drain.sv
// fifo_rr_drain: round-robin drain of N_FIFO first-word-fall-through
// fifos into one registered valid/ready stream tagged with the source
// index. The pop strobe is combinational so the word seen on fifo_dout
// in the grant cycle is captured into the output register at the edge.
// Optional macro FIFO_DRAIN_PERF_EN adds saturating pop/stall counters.
module fifo_rr_drain #(
    parameter int DWIDTH    = 16,
    parameter int N_FIFO    = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
`ifdef FIFO_DRAIN_PERF_EN
    output logic [N_FIFO*16-1:0] pop_count,
    output logic [15:0]          stall_count,
`endif
    fifo_rr_drain_if.master      bus
);

    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0] out_src_q, out_src_d;
    logic [DWIDTH-1:0]    out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;

    logic [IDX_WIDTH-1:0] grant_s;
    logic [DWIDTH-1:0]    grant_data_s;
    logic                 any_ne_s;
    logic                 load_s;
    logic [N_FIFO-1:0]    rd_en_s;
    int                   idx_v;

    // Round-robin search: walk from farthest to nearest offset so the last hit is the first non-empty from rr_ptr.
    always_comb begin
        grant_s      = '0;
        grant_data_s = '0;
        any_ne_s     = 1'b0;
        idx_v        = 0;
        for (int k = N_FIFO - 1; k >= 0; k--) begin
            idx_v        = int'(rr_ptr_q) + k;
            idx_v        = (idx_v >= N_FIFO) ? (idx_v - N_FIFO) : idx_v;
            grant_s      = (!bus.fifo_empty[idx_v]) ? IDX_WIDTH'(idx_v) : grant_s;
            grant_data_s = (!bus.fifo_empty[idx_v]) ? bus.fifo_dout[idx_v*DWIDTH +: DWIDTH] : grant_data_s;
            any_ne_s     = any_ne_s | ~bus.fifo_empty[idx_v];
        end
    end

    // Load decision, pop strobe decode and next-state of the output register and pointer.
    always_comb begin
        load_s      = enable & (~out_valid_q | bus.out_ready) & any_ne_s & ~rst;
        rd_en_s     = '0;
        rr_ptr_d    = rr_ptr_q;
        out_src_d   = out_src_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        for (int i = 0; i < N_FIFO; i++) begin
            rd_en_s[i] = load_s & (grant_s == IDX_WIDTH'(i));
        end
        if (load_s) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data_s;
            out_src_d   = grant_s;
            rr_ptr_d    = (grant_s == IDX_WIDTH'(N_FIFO - 1)) ? '0 : (grant_s + IDX_WIDTH'(1));
        end else if (out_valid_q & bus.out_ready) begin
            // Word accepted with nothing to replace it; data/src keep their last value.
            out_valid_d = 1'b0;
        end else begin
            // Stalled or idle: everything holds.
            out_valid_d = out_valid_q;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            out_src_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_src_q   <= out_src_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.fifo_rd_en = rd_en_s;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.out_valid  = out_valid_q;

`ifdef FIFO_DRAIN_PERF_EN
    logic [N_FIFO*16-1:0] pop_count_q, pop_count_d;
    logic [15:0]          stall_count_q, stall_count_d;

    // Saturating per-fifo pop counters and the output stall counter.
    always_comb begin
        pop_count_d   = pop_count_q;
        stall_count_d = stall_count_q;
        for (int i = 0; i < N_FIFO; i++) begin
            if (rd_en_s[i] && (pop_count_q[i*16 +: 16] != 16'hFFFF)) begin
                pop_count_d[i*16 +: 16] = pop_count_q[i*16 +: 16] + 16'd1;
            end else begin
                pop_count_d[i*16 +: 16] = pop_count_q[i*16 +: 16];
            end
        end
        if (out_valid_q && !bus.out_ready && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_count_q   <= '0;
            stall_count_q <= 16'd0;
        end else begin
            pop_count_q   <= pop_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pop_count   = pop_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Self-checking bench for fifo_rr_drain (N_FIFO=4, DWIDTH=16).
// Upstream fifos are modelled as queues; a queue-based reference model
// predicts pops and the output stream every cycle.
module tb_fifo_rr_drain;

    logic clk;
    logic rst;
    logic enable;
`ifdef FIFO_DRAIN_PERF_EN
    logic [63:0] pop_count;
    logic [15:0] stall_count;
`endif

    fifo_rr_drain_if #(.DWIDTH(16), .N_FIFO(4), .IDX_WIDTH(2)) bus ();

    fifo_rr_drain #(.DWIDTH(16), .N_FIFO(4), .IDX_WIDTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
`ifdef FIFO_DRAIN_PERF_EN
        .pop_count   (pop_count),
        .stall_count (stall_count),
`endif
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Fifo contents and reference model state
    logic [15:0] q [4][$];
    logic        m_valid;
    logic [15:0] m_data;
    int          m_src;
    int          m_ptr;
    int          m_stall;
    int          got [$];

    typedef struct {
        int cnt [4];
        int n;
        int seq [12];
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifos();
        for (int i = 0; i < 4; i++) begin
            bus.fifo_empty[i] = (q[i].size() == 0);
            bus.fifo_dout[i*16 +: 16] = (q[i].size() != 0) ? q[i][0] : 16'h0000;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 16'h0000;
        m_src   = 0;
        m_ptr   = 0;
        m_stall = 0;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < 4; k++) begin
            if (q[(m_ptr + k) % 4].size() != 0) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    // One clock: called at posedge+1, checks at negedge, advances model at posedge.
    task automatic cycle();
        int g;
        logic ld;
        logic [3:0] exp_rd;
        drive_fifos();
        @(negedge clk);
        g  = model_grant();
        ld = enable && (!m_valid || bus.out_ready) && (g >= 0);
        exp_rd = ld ? 4'(1 << g) : 4'h0;
        chk("rd_en", {28'd0, bus.fifo_rd_en}, {28'd0, exp_rd});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("out_data", {16'd0, bus.out_data}, {16'd0, m_data});
        chk("out_src", {30'd0, bus.out_src}, 32'(m_src));
`ifdef FIFO_DRAIN_PERF_EN
        chk("stall_count", {16'd0, stall_count}, 32'(m_stall));
`endif
        if (m_valid && bus.out_ready) got.push_back(m_src);
        @(posedge clk);
        if (m_valid && !bus.out_ready && m_stall != 65535) m_stall++;
        if (ld) begin
            m_data  = q[g].pop_front();
            m_src   = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % 4;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) q[i].delete();
        enable = 1'b0;
        bus.out_ready = 1'b0;
        drive_fifos();
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", {16'd0, bus.out_data}, 32'd0);
        chk("rst_src", {30'd0, bus.out_src}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        int budget;
        int busy;
        budget = 0;
        busy = 1;
        while (busy != 0 && budget < 200) begin
            cycle();
            budget++;
            busy = (m_valid || q[0].size() || q[1].size() || q[2].size() || q[3].size()) ? 1 : 0;
        end
        chk("drain_done", 32'(busy), 32'd0);
    endtask

    initial begin
        tbl[0].cnt = '{1, 0, 1, 0}; tbl[0].n = 2;
        tbl[0].seq = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].cnt = '{3, 3, 3, 3}; tbl[1].n = 12;
        tbl[1].seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        tbl[2].cnt = '{2, 0, 0, 1}; tbl[2].n = 3;
        tbl[2].seq = '{0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].cnt = '{0, 2, 1, 0}; tbl[3].n = 3;
        tbl[3].seq = '{1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4].cnt = '{0, 0, 0, 4}; tbl[4].n = 4;
        tbl[4].seq = '{3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b0;
        enable = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        drive_fifos();
        #2;

        // Table-driven drain orders from reset
        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < tbl[t].cnt[i]; j++)
                    q[i].push_back(16'(i * 4096 + t * 256 + j + 16));
            enable = 1'b1;
            bus.out_ready = 1'b1;
            got.delete();
            drain();
            chk($sformatf("tbl%0d_len", t), 32'(got.size()), 32'(tbl[t].n));
            for (int j = 0; j < tbl[t].n; j++)
                chk($sformatf("tbl%0d_src%0d", t, j), (j < got.size()) ? 32'(got[j]) : 32'hFF, 32'(tbl[t].seq[j]));
            if (t == 1) begin
                // pointer wrapped back to 0 after 12 words
                q[1].push_back(16'h0B01);
                q[0].push_back(16'h0B00);
                got.delete();
                drain();
                chk("wrap_first", (got.size() > 0) ? 32'(got[0]) : 32'hFF, 32'd0);
            end
        end

        // Stall: first word 0x1234 held for 5 cycles
        do_reset();
        q[0].push_back(16'h1234);
        q[1].push_back(16'h5678);
        enable = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        repeat (5) cycle();
        chk("stall_data", {16'd0, bus.out_data}, 32'h1234);
        chk("stall_q1", 32'(q[1].size()), 32'd1);
`ifdef FIFO_DRAIN_PERF_EN
        chk("stall_cnt5", {16'd0, stall_count}, 32'd5);
`endif
        bus.out_ready = 1'b1;
        drain();

        // enable dropped while a word is held
        do_reset();
        q[1].push_back(16'hAAA1);
        q[1].push_back(16'hAAA2);
        enable = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        enable = 1'b0;
        got.delete();
        repeat (3) cycle();
        chk("en0_delivered", 32'(got.size()), 32'd1);
        chk("en0_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("en0_q1", 32'(q[1].size()), 32'd1);
        enable = 1'b1;
        drain();

        // Only fifo3 busy with rr_ptr=1
        do_reset();
        q[0].push_back(16'h0C00);
        enable = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        for (int j = 0; j < 4; j++) q[3].push_back(16'(16'h3C00 + j));
        got.delete();
        drain();
        chk("f3_len", 32'(got.size()), 32'd5);
        for (int j = 1; j < 5; j++)
            chk($sformatf("f3_src%0d", j), (j < got.size()) ? 32'(got[j]) : 32'hFF, 32'd3);

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) q[i].push_back(16'(16'h5000 + i * 16 + j));
        enable = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        drive_fifos();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_rd_en", {28'd0, bus.fifo_rd_en}, 32'd0);
        @(negedge clk);
        chk("mid_rst_rd_en2", {28'd0, bus.fifo_rd_en}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        got.delete();
        drain();
        chk("post_rst_first", (got.size() > 0) ? 32'(got[0]) : 32'hFF, 32'd0);

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int f;
                f = $urandom_range(0, 3);
                if (q[f].size() < 8) q[f].push_back(16'($urandom));
            end
            enable = ($urandom_range(0, 7) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        enable = 1'b1;
        bus.out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
